// File: rtl/aes_block_sequencer.sv
// aes_block_sequencer: control path between a word stream and an AES core.
// Gathers NB_CHUNKS stream words into one block, starts the core, waits for
// its result and streams it back out, repeating for a programmed block count.
// Optional build macro AES_BLOCK_SEQ_TIMEOUT_EN adds a WORK-state watchdog
// (parameter TIMEOUT_CYCLES, output timeout_o).
module aes_block_sequencer #(
  parameter int BLOCK_WIDTH  = 128,
  parameter int STREAM_WIDTH = 32,
  parameter int CNT_WIDTH    = 16
`ifdef AES_BLOCK_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [CNT_WIDTH-1:0]    num_blocks_i,
  input  logic [STREAM_WIDTH-1:0] in_data_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [BLOCK_WIDTH-1:0]  core_block_o,
  output logic                    core_start_o,
  input  logic                    core_done_i,
  input  logic [BLOCK_WIDTH-1:0]  core_result_i,
  output logic [STREAM_WIDTH-1:0] out_data_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_WIDTH-1:0]    blocks_done_o
`ifdef AES_BLOCK_SEQ_TIMEOUT_EN
  , output logic                  timeout_o
`endif
);

  localparam int NB_CHUNKS = BLOCK_WIDTH / STREAM_WIDTH;
  localparam int IW        = (NB_CHUNKS > 1) ? $clog2(NB_CHUNKS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NB_CHUNKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WORK, S_SEND, S_FINISH
  } state_e;

  state_e state_q, state_d;

  logic [NB_CHUNKS-1:0][STREAM_WIDTH-1:0] in_buf, out_buf;
  logic [IW-1:0]        in_idx, out_idx;
  logic [CNT_WIDTH-1:0] num_q;
  logic                 zero_done_q;
  logic                 in_hs, out_hs, last_in, last_out, last_blk;

  assign in_hs    = in_valid_i && (state_q == S_LOAD);
  assign out_hs   = out_ready_i && (state_q == S_SEND);
  assign last_in  = in_hs && (in_idx == LAST);
  assign last_out = out_hs && (out_idx == LAST);
  // Compared at CNT_WIDTH so the count wraps like the register itself.
  assign last_blk = (blocks_done_o + CNT_WIDTH'(1)) == num_q;

`ifdef AES_BLOCK_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_q, timeout_hit;

  // Counter holds 0 outside WORK, so it restarts on every WORK entry.
  assign timeout_hit = (state_q == S_WORK) && !core_done_i &&
                       (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter and one-cycle timeout pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else if (clear_i) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q   <= timeout_hit;
      tmo_cnt <= (state_q == S_WORK) ? tmo_cnt + TW'(1) : '0;
    end
  end

  assign timeout_o = tmo_q;
`endif

  // State register; clear aborts any job straight back to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      state_q <= S_IDLE;
    else if (clear_i) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_i && (num_blocks_i != '0)) state_d = S_LOAD;
      S_LOAD:   if (last_in) state_d = S_START;
      S_START:  state_d = S_WORK;
      S_WORK: begin
        if (core_done_i) state_d = S_SEND;
`ifdef AES_BLOCK_SEQ_TIMEOUT_EN
        else if (timeout_hit) state_d = S_IDLE;
`endif
      end
      S_SEND:   if (last_out) state_d = last_blk ? S_FINISH : S_LOAD;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; out_data is forced to 0 when not presenting.
  always_comb begin
    in_ready_o   = (state_q == S_LOAD);
    core_start_o = (state_q == S_START);
    out_valid_o  = (state_q == S_SEND);
    out_data_o   = (state_q == S_SEND) ? out_buf[out_idx] : '0;
    busy_o       = (state_q != S_IDLE);
    done_o       = (state_q == S_FINISH) || zero_done_q;
  end

  assign core_block_o = in_buf;

  // Datapath: word buffers, word indices, job count and progress counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_buf        <= '0;
      out_buf       <= '0;
      in_idx        <= '0;
      out_idx       <= '0;
      num_q         <= '0;
      blocks_done_o <= '0;
      zero_done_q   <= 1'b0;
    end else if (clear_i) begin
      in_buf        <= '0;
      out_buf       <= '0;
      in_idx        <= '0;
      out_idx       <= '0;
      num_q         <= '0;
      blocks_done_o <= '0;
      zero_done_q   <= 1'b0;
    end else begin
      // An empty job completes immediately with a single done pulse.
      zero_done_q <= (state_q == S_IDLE) && start_i && (num_blocks_i == '0);
      // Any accepted start begins a fresh job, so progress restarts at 0.
      if ((state_q == S_IDLE) && start_i) begin
        num_q         <= num_blocks_i;
        blocks_done_o <= '0;
        in_idx        <= '0;
        out_idx       <= '0;
      end
      if (in_hs) begin
        in_buf[in_idx] <= in_data_i;
        in_idx         <= (in_idx == LAST) ? '0 : in_idx + IW'(1);
      end
      if ((state_q == S_WORK) && core_done_i) out_buf <= core_result_i;
      if (out_hs) begin
        out_idx <= (out_idx == LAST) ? '0 : out_idx + IW'(1);
        if (out_idx == LAST) blocks_done_o <= blocks_done_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Self-checking bench for aes_block_sequencer. A single per-cycle routine
// acts as stream source, stream sink and AES core model; expected blocks and
// output words come from queues of the words actually accepted, with the
// core modelled as bitwise inversion of its input block.
module tb_aes_block_sequencer;

  localparam int BW = 128;
  localparam int SW = 32;
  localparam int NB = BW / SW;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n, clear, start;
  logic [CW-1:0] num_blocks;
  logic [SW-1:0] in_data;
  logic          in_valid, in_ready;
  logic [BW-1:0] core_block;
  logic          core_start, core_done;
  logic [BW-1:0] core_result;
  logic [SW-1:0] out_data;
  logic          out_valid, out_ready;
  logic          busy, done;
  logic [CW-1:0] blocks_done;
`ifdef AES_BLOCK_SEQ_TIMEOUT_EN
  logic          timeout;
`endif

  always #5 clk = ~clk;

  aes_block_sequencer #(
    .BLOCK_WIDTH(BW), .STREAM_WIDTH(SW), .CNT_WIDTH(CW)
`ifdef AES_BLOCK_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
    .num_blocks_i(num_blocks), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .core_block_o(core_block), .core_start_o(core_start),
    .core_done_i(core_done), .core_result_i(core_result), .out_data_o(out_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy),
    .done_o(done), .blocks_done_o(blocks_done)
`ifdef AES_BLOCK_SEQ_TIMEOUT_EN
    , .timeout_o(timeout)
`endif
  );

  int n_tests = 0, n_fail = 0;

  logic [SW-1:0] feed_q[$], acc_q[$], exp_q[$];
  bit            rdy_prev = 0, ov_prev = 0;
  logic [SW-1:0] od_prev = '0;
  logic [BW-1:0] res_pend = '0, last_blk = '0;
  int hs_cnt, start_cnt, done_cnt, cd;
  int gap_max, rmode, lat_fix, hold_at;
  bit spur, spur_s, spur_d;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: account for the handshakes of the last edge, check,
  // then drive the next cycle's inputs.
  task automatic tick();
    bit in_hs, out_hs;
    logic [BW-1:0] blk;
    @(negedge clk);
    in_hs  = in_valid && rdy_prev && !clear && rst_n;
    out_hs = ov_prev && out_ready && !clear && rst_n;
    if (in_hs) begin
      acc_q.push_back(in_data);
      in_valid = 1'b0;
    end
    if (out_hs) begin
      hs_cnt++;
      if (exp_q.size() == 0) chk("out_unexpected", od_prev, 'x);
      else chk("out_data", od_prev, exp_q.pop_front());
      if (hs_cnt % NB == 0) chk("blocks_done_step", blocks_done, hs_cnt / NB);
    end
    if (ov_prev && !out_ready && !clear) begin
      chk("valid_hold", out_valid, 1);
      chk("data_hold", out_data, od_prev);
    end
    if (done) done_cnt++;
    // core model: response countdown
    core_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        core_done   = 1'b1;
        core_result = res_pend;
      end
    end else if (spur && !spur_d && in_ready) begin
      core_done   = 1'b1;
      core_result = {$urandom(), $urandom(), $urandom(), $urandom()};
      spur_d      = 1'b1;
    end
    if (core_start) begin
      start_cnt++;
      chk("start_words", acc_q.size(), NB);
      blk = '0;
      for (int k = 0; k < NB; k++)
        if (acc_q.size() > 0) blk[k*SW +: SW] = acc_q.pop_front();
      chk("core_block", core_block, blk);
      last_blk = core_block;
      if (start_cnt != hold_at) begin
        cd       = (lat_fix > 0) ? lat_fix : int'($urandom_range(12, 1));
        res_pend = ~blk;
        for (int k = 0; k < NB; k++) exp_q.push_back(res_pend[k*SW +: SW]);
      end
    end
    start = 1'b0;
    if (spur && !spur_s && out_valid) begin
      start      = 1'b1;
      num_blocks = 16'd7;
      spur_s     = 1'b1;
    end
    if (!in_valid && feed_q.size() > 0 && $urandom_range(gap_max, 0) == 0) begin
      in_valid = 1'b1;
      in_data  = feed_q.pop_front();
    end
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = !out_ready;
      default: out_ready = 1'($urandom_range(1, 0));
    endcase
    rdy_prev = in_ready;
    ov_prev  = out_valid;
    od_prev  = out_data;
  endtask

  task automatic setup(input int g, input int rm, input int lat, input bit sp, input int hold);
    gap_max = g; rmode = rm; lat_fix = lat; spur = sp; hold_at = hold;
    spur_s = 0; spur_d = 0; hs_cnt = 0; start_cnt = 0; done_cnt = 0; cd = 0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n * NB; i++) feed_q.push_back($urandom());
  endtask

  task automatic flush();
    feed_q.delete(); acc_q.delete(); exp_q.delete();
    in_valid = 1'b0; cd = 0;
  endtask

  // Runs a job of n blocks (feed_q already filled) and checks its totals.
  task automatic job(input int n);
    int bound;
    start = 1'b1; num_blocks = CW'(n);
    tick();
    chk("busy_run", busy, 1);
    bound = 0;
    while (done_cnt == 0 && bound < 4000) begin tick(); bound++; end
    chk("job_bound", bound < 4000, 1);
    repeat (3) tick();
    chk("done_once", done_cnt, 1);
    chk("handshakes", hs_cnt, n * NB);
    chk("core_starts", start_cnt, n);
    chk("blocks_done", blocks_done, n);
    chk("exp_drained", exp_q.size(), 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int bound;
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; num_blocks = '0;
    in_data = '0; in_valid = 1'b0; core_done = 1'b0; core_result = '0; out_ready = 1'b0;
    setup(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_block", core_block, 0);
    chk("rst_done", done, 0);
    chk("rst_blocks_done", blocks_done, 0);
    rst_n = 1'b1;
    tick();

    // directed single block, core latency 10
    setup(0, 0, 10, 0, 0);
    feed_q = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    job(1);
    chk("directed_block", last_blk, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

    // three blocks, toggling sink, input gaps
    setup(3, 1, 0, 0, 0);
    fill(3);
    job(3);

    // empty job
    setup(0, 0, 0, 0, 0);
    start = 1'b1; num_blocks = '0;
    tick();
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    tick();
    chk("zero_done_drop", done, 0);
    chk("zero_in_ready", in_ready, 0);
    chk("zero_busy2", busy, 0);
    chk("zero_starts", start_cnt, 0);
    chk("zero_done_cnt", done_cnt, 1);

    // spurious start in SEND and core_done in LOAD
    setup(1, 2, 0, 1, 0);
    fill(2);
    job(2);
    chk("spur_start_seen", spur_s, 1);
    chk("spur_done_seen", spur_d, 1);

    // abort in WORK of block 2 of 4
    setup(0, 0, 0, 0, 2);
    fill(4);
    start = 1'b1; num_blocks = 16'd4;
    tick();
    bound = 0;
    while (start_cnt < 2 && bound < 2000) begin tick(); bound++; end
    chk("abort_reach", start_cnt, 2);
    repeat (3) tick();
    chk("abort_pre_busy", busy, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_core_start", core_start, 0);
    chk("abort_core_block", core_block, 0);
    chk("abort_blocks_done", blocks_done, 0);
    flush();
    core_done = 1'b1; core_result = {4{32'hDEADBEEF}};
    tick();
    repeat (3) tick();
    chk("abort_late_busy", busy, 0);
    chk("abort_late_valid", out_valid, 0);
    chk("abort_no_done", done_cnt, 0);
    setup(0, 0, 0, 0, 0);
    fill(1);
    job(1);

    // randomized jobs
    for (int j = 0; j < 4; j++) begin
      int n;
      n = int'($urandom_range(4, 1));
      setup(int'($urandom_range(3, 0)), int'($urandom_range(2, 0)), 0, 0, 0);
      fill(n);
      job(n);
    end

`ifdef AES_BLOCK_SEQ_TIMEOUT_EN
    begin
      int t;
      setup(0, 0, 0, 0, 1);
      fill(1);
      start = 1'b1; num_blocks = 16'd1;
      tick();
      bound = 0;
      while (start_cnt < 1 && bound < 200) begin tick(); bound++; end
      t = 0;
      while (!timeout && t < 100) begin tick(); t++; end
      chk("timeout_delay", t, 17);
      tick();
      chk("timeout_pulse", timeout, 0);
      chk("timeout_busy", busy, 0);
      chk("timeout_no_done", done_cnt, 0);
      flush();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
